// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive timing path.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } morse_state_t;

    localparam logic [1:0] GAP_LETTER = 2'b01;
    localparam logic [1:0] GAP_WORD   = 2'b10;

    localparam int CAL_SAMPLES = 4;
    localparam int CAL_SHIFT   = $clog2(CAL_SAMPLES);

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser plus stability counter for the raw key line.
// Level and edge strobes change together, after DEBOUNCE stable cycles.
module morse_debounce #(
    parameter int DEBOUNCE = 1000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_fall  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/morse_timing_ctrl.sv
// Mark/space timing, element and gap classification, dot-unit calibration
// and tracking for the Morse receive path.
module morse_timing_ctrl
    import morse_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int DOT_INIT = 1000000,
    parameter int DOT_MIN  = 10000,
    parameter int DOT_MAX  = 4000000,
    parameter int DEBOUNCE = 1000,
    parameter int ADAPT    = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_morse_in,
    input  logic             i_cal_start,
    output logic             o_mark_valid,
    output logic             o_mark_is_dash,
    output logic [CNT_W-1:0] o_mark_len,
    output logic             o_gap_valid,
    output logic [1:0]       o_gap_kind,
    output logic [CNT_W-1:0] o_dot_unit,
    output logic [CNT_W-1:0] o_dash_thr,
    output logic [CNT_W-1:0] o_letter_thr,
    output logic [CNT_W-1:0] o_word_thr,
    output logic             o_cal_busy,
    output logic             o_cal_done,
    output logic             o_cal_err
);

    function automatic logic [CNT_W-1:0] sat_scale(input logic [CNT_W-1:0] v,
                                                   input logic [2:0] k);
        logic [CNT_W+2:0] p;
        p = {3'b000, v} * {{CNT_W{1'b0}}, k};
        return (|p[CNT_W+2:CNT_W]) ? '1 : p[CNT_W-1:0];
    endfunction

    logic w_level, w_rise, w_fall;

    morse_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (i_morse_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    morse_state_t         r_state;
    logic [CNT_W-1:0]     r_mark_cnt;
    logic [CNT_W-1:0]     r_space_cnt;
    logic [CNT_W-1:0]     r_dot;
    logic                 r_mark_valid;
    logic                 r_mark_is_dash;
    logic [CNT_W-1:0]     r_mark_len;
    logic                 r_gap_valid;
    logic [1:0]           r_gap_kind;
    logic                 r_cal_busy;
    logic                 r_cal_done;
    logic                 r_cal_err;
    logic [CNT_W+1:0]     r_cal_acc;
    logic [CAL_SHIFT-1:0] r_cal_n;
    logic                 r_mark_cal;
    logic                 r_trk_pend;

    logic [CNT_W-1:0] w_dash_thr, w_letter_thr, w_word_thr;
    logic [CNT_W-1:0] w_mark_next, w_space_next;
    logic             w_is_dash;
    logic [CNT_W+1:0] w_cal_sum, w_cal_shifted;
    logic             w_cal_last, w_avg_ok;
    logic [CNT_W:0]   w_trk;
    logic [CNT_W-1:0] w_trk_dot;

    assign w_dash_thr   = sat_scale(r_dot, 3'd2);
    assign w_letter_thr = w_dash_thr;
    assign w_word_thr   = sat_scale(r_dot, 3'd5);

    assign w_mark_next  = (&r_mark_cnt)  ? r_mark_cnt  : r_mark_cnt + CNT_W'(1);
    assign w_space_next = (&r_space_cnt) ? r_space_cnt : r_space_cnt + CNT_W'(1);
    assign w_is_dash    = (r_mark_cnt >= w_dash_thr);

    // The accumulator carries two extra bits so four full-scale marks cannot wrap.
    assign w_cal_sum     = r_cal_acc + {2'b00, r_mark_cnt};
    assign w_cal_shifted = w_cal_sum >> CAL_SHIFT;
    assign w_cal_last    = (r_cal_n == CAL_SHIFT'(CAL_SAMPLES - 1));
    assign w_avg_ok      = (w_cal_shifted >= (CNT_W+2)'(DOT_MIN)) &&
                           (w_cal_shifted <= (CNT_W+2)'(DOT_MAX));

    assign w_trk = {1'b0, r_dot} - {4'b0000, r_dot[CNT_W-1:3]}
                                 + {4'b0000, r_mark_len[CNT_W-1:3]};
    always_comb begin
        w_trk_dot = w_trk[CNT_W-1:0];
        if (w_trk < (CNT_W+1)'(DOT_MIN)) w_trk_dot = CNT_W'(DOT_MIN);
        else if (w_trk > (CNT_W+1)'(DOT_MAX)) w_trk_dot = CNT_W'(DOT_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_mark_cnt     <= '0;
            r_space_cnt    <= '0;
            r_dot          <= CNT_W'(DOT_INIT);
            r_mark_valid   <= 1'b0;
            r_mark_is_dash <= 1'b0;
            r_mark_len     <= '0;
            r_gap_valid    <= 1'b0;
            r_gap_kind     <= '0;
            r_cal_busy     <= 1'b0;
            r_cal_done     <= 1'b0;
            r_cal_err      <= 1'b0;
            r_cal_acc      <= '0;
            r_cal_n        <= '0;
            r_mark_cal     <= 1'b0;
            r_trk_pend     <= 1'b0;
        end else begin
            r_mark_valid <= 1'b0;
            r_gap_valid  <= 1'b0;
            r_cal_done   <= 1'b0;
            r_trk_pend   <= 1'b0;
            if (r_trk_pend) r_dot <= w_trk_dot;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state    <= ST_MARK;
                        r_mark_cnt <= CNT_W'(1);
                        r_mark_cal <= r_cal_busy;
                    end
                end
                ST_MARK: begin
                    if (w_fall) begin
                        r_state     <= ST_SPACE;
                        r_space_cnt <= CNT_W'(1);
                        if (r_cal_busy) begin
                            if (r_mark_cal) begin
                                r_cal_acc <= w_cal_sum;
                                r_cal_n   <= r_cal_n + CAL_SHIFT'(1);
                                if (w_cal_last) begin
                                    r_cal_busy <= 1'b0;
                                    if (w_avg_ok) begin
                                        r_dot      <= w_cal_shifted[CNT_W-1:0];
                                        r_cal_done <= 1'b1;
                                    end else begin
                                        r_cal_err <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            r_mark_valid   <= 1'b1;
                            r_mark_is_dash <= w_is_dash;
                            r_mark_len     <= r_mark_cnt;
                            r_trk_pend     <= (ADAPT != 0) && !w_is_dash;
                        end
                    end else if (w_level) begin
                        r_mark_cnt <= w_mark_next;
                    end
                end
                ST_SPACE: begin
                    if (w_rise) begin
                        r_state     <= ST_MARK;
                        r_space_cnt <= '0;
                        r_mark_cnt  <= CNT_W'(1);
                        r_mark_cal  <= r_cal_busy;
                    end else begin
                        r_space_cnt <= w_space_next;
                        if (w_space_next == w_word_thr) begin
                            r_state <= ST_IDLE;
                            if (r_cal_busy) begin
                                r_cal_busy <= 1'b0;
                                r_cal_err  <= 1'b1;
                            end else begin
                                r_gap_valid <= 1'b1;
                                r_gap_kind  <= GAP_WORD;
                            end
                        end else if ((w_space_next == w_letter_thr) && !r_cal_busy) begin
                            r_gap_valid <= 1'b1;
                            r_gap_kind  <= GAP_LETTER;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Clearing r_mark_cal here drops a mark already in progress.
            if (i_cal_start && !r_cal_busy) begin
                r_cal_busy <= 1'b1;
                r_cal_err  <= 1'b0;
                r_cal_acc  <= '0;
                r_cal_n    <= '0;
                r_mark_cal <= 1'b0;
            end
        end
    end

    assign o_mark_valid   = r_mark_valid;
    assign o_mark_is_dash = r_mark_is_dash;
    assign o_mark_len     = r_mark_len;
    assign o_gap_valid    = r_gap_valid;
    assign o_gap_kind     = r_gap_kind;
    assign o_dot_unit     = r_dot;
    assign o_dash_thr     = w_dash_thr;
    assign o_letter_thr   = w_letter_thr;
    assign o_word_thr     = w_word_thr;
    assign o_cal_busy     = r_cal_busy;
    assign o_cal_done     = r_cal_done;
    assign o_cal_err      = r_cal_err;

endmodule

// File: tb/tb_morse_timing_ctrl.sv
// Directed bench for morse_timing_ctrl: event scoreboard on a fixed-dot instance
// plus a second instance with dot tracking enabled.
module tb_morse_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, morse, cal, morse_a, cal_a;
    logic        mv, dsh, gv, busy, done, err;
    logic [31:0] ml, dot, dthr, lthr, wthr;
    logic [1:0]  gk;
    logic        mv_a, dsh_a, gv_a, busy_a, done_a, err_a;
    logic [31:0] ml_a, dot_a, dthr_a, lthr_a, wthr_a;
    logic [1:0]  gk_a;

    morse_timing_ctrl #(.CNT_W(32), .DOT_INIT(100), .DOT_MIN(20), .DOT_MAX(1000),
                        .DEBOUNCE(4), .ADAPT(0)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_morse_in(morse), .i_cal_start(cal),
        .o_mark_valid(mv), .o_mark_is_dash(dsh), .o_mark_len(ml),
        .o_gap_valid(gv), .o_gap_kind(gk), .o_dot_unit(dot),
        .o_dash_thr(dthr), .o_letter_thr(lthr), .o_word_thr(wthr),
        .o_cal_busy(busy), .o_cal_done(done), .o_cal_err(err)
    );

    morse_timing_ctrl #(.CNT_W(32), .DOT_INIT(100), .DOT_MIN(20), .DOT_MAX(1000),
                        .DEBOUNCE(4), .ADAPT(1)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_morse_in(morse_a), .i_cal_start(cal_a),
        .o_mark_valid(mv_a), .o_mark_is_dash(dsh_a), .o_mark_len(ml_a),
        .o_gap_valid(gv_a), .o_gap_kind(gk_a), .o_dot_unit(dot_a),
        .o_dash_thr(dthr_a), .o_letter_thr(lthr_a), .o_word_thr(wthr_a),
        .o_cal_busy(busy_a), .o_cal_done(done_a), .o_cal_err(err_a)
    );

    typedef struct {
        bit         is_gap;
        bit         dash;
        int         len;
        logic [1:0] kind;
        int         dly;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  ref_cyc = 0;
    int  n_done = 0;
    int  n_ev = 0;
    int  model_dot = 100;
    int  saved;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge, and score any event.
    task automatic step();
        ev_t e;
        @(negedge clk);
        cyc++;
        if (mv || gv) begin
            n_ev++;
            chk("mv_gv_exclusive", 64'(mv & gv), 64'(0));
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_event: observed mv=%0d gv=%0d kind=%0d expected none",
                       mv, gv, gk);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                if (mv) begin
                    chk("event_order_mark", 64'(e.is_gap), 64'(0));
                    chk("mark_is_dash", 64'(dsh), 64'(e.dash));
                    n_tests++;
                    assert ((int'(ml) >= e.len - 1) && (int'(ml) <= e.len + 1)) else begin
                        n_fail++;
                        $error("FAIL mark_len: observed %0d expected %0d+-1", ml, e.len);
                    end
                    ref_cyc = cyc;
                end else begin
                    chk("event_order_gap", 64'(e.is_gap), 64'(1));
                    chk("gap_kind", 64'(gk), 64'(e.kind));
                    chk("gap_delay", 64'(cyc - ref_cyc), 64'(e.dly));
                end
            end
        end
        if (done) begin
            n_done++;
            ref_cyc = cyc;
        end
    endtask

    task automatic key(input logic v, input int n);
        morse = v;
        repeat (n) step();
    endtask

    task automatic exp_mark(input int len);
        ev_t e;
        e.is_gap = 1'b0;
        e.dash   = (len >= 2 * model_dot);
        e.len    = len;
        e.kind   = 2'b00;
        e.dly    = 0;
        q.push_back(e);
    endtask

    // Gap delays are measured from the mark_valid (or cal_done) cycle, where the space count is 1.
    task automatic exp_gaps(input bit with_word);
        ev_t e;
        e.is_gap = 1'b1;
        e.dash   = 1'b0;
        e.len    = 0;
        e.kind   = 2'b01;
        e.dly    = 2 * model_dot - 1;
        q.push_back(e);
        if (with_word) begin
            e.kind = 2'b10;
            e.dly  = 5 * model_dot - 1;
            q.push_back(e);
        end
    endtask

    task automatic pulse_cal();
        cal = 1'b1;
        step();
        cal = 1'b0;
    endtask

    task automatic wait_mv_a(input string tag);
        int i;
        i = 0;
        while (!mv_a && i < 50) begin
            step();
            i++;
        end
        chk(tag, 64'(mv_a), 64'(1));
    endtask

    initial begin
        rst = 1'b1; morse = 1'b0; cal = 1'b0; morse_a = 1'b0; cal_a = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_dot_unit",   64'(dot),  64'(100));
        chk("rst_dash_thr",   64'(dthr), 64'(200));
        chk("rst_letter_thr", 64'(lthr), 64'(200));
        chk("rst_word_thr",   64'(wthr), 64'(500));
        chk("rst_cal_busy",   64'(busy), 64'(0));
        chk("rst_cal_err",    64'(err),  64'(0));
        chk("rst_cal_done",   64'(done), 64'(0));
        chk("rst_mark_valid", 64'(mv),   64'(0));
        chk("rst_gap_valid",  64'(gv),   64'(0));
        chk("rst_mark_len",   64'(ml),   64'(0));
        chk("rst_gap_kind",   64'(gk),   64'(0));
        chk("rst_mark_dash",  64'(dsh),  64'(0));
        chk("rst_dot_adapt",  64'(dot_a), 64'(100));

        // Dot tracking on the adaptive instance.
        morse_a = 1'b1;
        repeat (108) step();
        morse_a = 1'b0;
        wait_mv_a("adapt_dot_seen");
        chk("adapt_dot_class", 64'(dsh_a), 64'(0));
        chk("adapt_dot_before", 64'(dot_a), 64'(100));
        step();
        chk("adapt_dot_after", 64'(dot_a), 64'(101));
        repeat (50) step();
        morse_a = 1'b1;
        repeat (300) step();
        morse_a = 1'b0;
        wait_mv_a("adapt_dash_seen");
        chk("adapt_dash_class", 64'(dsh_a), 64'(1));
        step();
        step();
        chk("adapt_dash_no_track", 64'(dot_a), 64'(101));
        chk("adapt_dash_thr", 64'(dthr_a), 64'(202));

        // Elements and gaps at dot 100.
        key(1'b0, 10);
        exp_mark(100);
        key(1'b1, 100);
        exp_gaps(1'b0);
        key(1'b0, 250);
        exp_mark(300);
        key(1'b1, 300);
        exp_gaps(1'b1);
        key(1'b0, 600);
        key(1'b0, 100);
        chk("sb_elements_drained", 64'(q.size()), 64'(0));

        // Sub-debounce glitch.
        saved = n_ev;
        key(1'b1, 3);
        key(1'b0, 50);
        chk("glitch_no_event", 64'(n_ev), 64'(saved));
        chk("glitch_dot", 64'(dot), 64'(100));

        // Successful calibration to 60.
        n_done = 0;
        pulse_cal();
        chk("cal_busy_set", 64'(busy), 64'(1));
        chk("cal_err_clear", 64'(err), 64'(0));
        for (int k = 0; k < 3; k++) begin
            key(1'b1, 60);
            key(1'b0, 60);
        end
        key(1'b1, 60);
        model_dot = 60;
        exp_gaps(1'b1);
        key(1'b0, 400);
        chk("cal_done_pulses", 64'(n_done), 64'(1));
        chk("cal_dot_unit",    64'(dot),  64'(60));
        chk("cal_dash_thr",    64'(dthr), 64'(120));
        chk("cal_letter_thr",  64'(lthr), 64'(120));
        chk("cal_word_thr",    64'(wthr), 64'(300));
        chk("cal_busy_end",    64'(busy), 64'(0));
        chk("cal_err_ok",      64'(err),  64'(0));
        chk("sb_cal_drained",  64'(q.size()), 64'(0));

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        model_dot = 100;
        chk("rst2_dot_unit", 64'(dot), 64'(100));
        chk("rst2_dash_thr", 64'(dthr), 64'(200));

        // Calibration with marks below DOT_MIN.
        n_done = 0;
        pulse_cal();
        for (int k = 0; k < 4; k++) begin
            key(1'b1, 10);
            key(1'b0, 60);
        end
        chk("cal_short_err",  64'(err),  64'(1));
        chk("cal_short_busy", 64'(busy), 64'(0));
        chk("cal_short_dot",  64'(dot),  64'(100));
        chk("cal_short_done", 64'(n_done), 64'(0));

        // Calibration aborted by a word-length space.
        pulse_cal();
        chk("cal2_err_clear", 64'(err), 64'(0));
        chk("cal2_busy", 64'(busy), 64'(1));
        key(1'b1, 60);
        key(1'b0, 600);
        chk("cal_abort_err",  64'(err),  64'(1));
        chk("cal_abort_busy", 64'(busy), 64'(0));
        chk("cal_abort_dot",  64'(dot),  64'(100));

        // Reset in the middle of a calibration mark.
        pulse_cal();
        chk("cal3_busy", 64'(busy), 64'(1));
        key(1'b1, 30);
        rst = 1'b1;
        morse = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_cal_busy_clr", 64'(busy), 64'(0));
        chk("rst_cal_err_clr",  64'(err),  64'(0));
        chk("rst_cal_dot",      64'(dot),  64'(100));

        key(1'b0, 10);
        exp_mark(100);
        key(1'b1, 100);
        exp_gaps(1'b1);
        key(1'b0, 600);
        key(1'b0, 20);
        chk("sb_final_drained", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
